shift_seq_ctrl: RTL and testbench

- Multi-cycle shift sequencer for the 16-bit CPU datapath.
- Accepts one shift command: operation, operand and shift amount. Applies the existing single-step `shifter` datapath repeatedly, one step per clock, until the requested amount is reached.
- Sits between the instruction decode/execute control and the shifter. Gives the ALU path N-bit shifts and rotates through a start/busy/done handshake.

---
 rtl/shift_pkg.sv | 30 +++
 rtl/shifter.sv | 32 +++
 rtl/shift_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer and its single-step
// shifter datapath: operation codes, FSM state encoding and op classification.
package shift_pkg;

   localparam logic [2:0] SH_PASS  = 3'b000;
   localparam logic [2:0] SH_ASR   = 3'b001;
   localparam logic [2:0] SH_LSR   = 3'b010;
   localparam logic [2:0] SH_LSL   = 3'b011;
   localparam logic [2:0] SH_ROR   = 3'b100;
   localparam logic [2:0] SH_ROL   = 3'b101;
   localparam logic [2:0] SH_SWAP  = 3'b110;
   localparam logic [2:0] SH_PASS2 = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // True for the ops that are applied once per step (shifts and rotates).
   function automatic logic is_step_op(input logic [2:0] op);
      logic res;
      case (op)
         SH_ASR, SH_LSR, SH_LSL, SH_ROR, SH_ROL: res = 1'b1;
         default:                                res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/shifter.sv
// Single-step combinational shifter: one bit position per evaluation for
// shifts/rotates, a low-byte nibble exchange for swap, identity otherwise.
module shifter
   import shift_pkg::*;
#(
   parameter int BW = 16
) (
   input  logic [BW-1:0] a,
   input  logic [2:0]    sel,
   input  logic          inR,
   input  logic          inL,
   output logic [BW-1:0] y
);

   // Select the one-step transformation of a.
   always_comb begin
      y = a;
      case (sel)
         SH_ASR:  y = {a[BW-1], a[BW-1:1]};
         SH_LSR:  y = {inR, a[BW-1:1]};
         SH_LSL:  y = {a[BW-2:0], inL};
         SH_ROR:  y = {a[0], a[BW-1:1]};
         SH_ROL:  y = {a[BW-2:0], a[BW-1]};
         SH_SWAP: begin
            y[7:4] = a[3:0];
            y[3:0] = a[7:4];
         end
         default: y = a;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts one command through start/busy/done
// and applies the single-step shifter once per clock until amt steps are done.
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int BW    = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [BW-1:0]    din,
   input  logic [AMT_W-1:0] amt,
   input  logic             fill,
   output logic             busy,
   output logic             done,
   output logic [BW-1:0]    dout
);

   state_t             state_r, state_next_s;
   logic [AMT_W-1:0]   count_r, count_next_s;
   logic [2:0]         op_r, op_next_s;
   logic               fill_r, fill_next_s;
   logic [BW-1:0]      dout_r, dout_next_s;
   logic               busy_r, done_r;
   logic [BW-1:0]      sh_a_s, sh_y_s;
   logic [2:0]         sh_sel_s;

   // In SHIFT the shifter steps the result register with the latched op;
   // in IDLE it sees the raw operand so the one-shot swap can be loaded.
   always_comb begin
      sh_a_s   = din;
      sh_sel_s = op;
      if (state_r == SHIFT) begin
         sh_a_s   = dout_r;
         sh_sel_s = op_r;
      end else begin
         sh_a_s   = din;
         sh_sel_s = op;
      end
   end

   shifter #(.BW(BW)) u_shifter (
      .a   (sh_a_s),
      .sel (sh_sel_s),
      .inR (fill_r),
      .inL (fill_r),
      .y   (sh_y_s)
   );

   // Next-state, next-count and next-result logic for the sequencer.
   always_comb begin
      state_next_s = state_r;
      count_next_s = count_r;
      op_next_s    = op_r;
      fill_next_s  = fill_r;
      dout_next_s  = dout_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               op_next_s    = op;
               fill_next_s  = fill;
               count_next_s = amt;
               if (is_step_op(op) && (amt != {AMT_W{1'b0}})) begin
                  dout_next_s  = din;
                  state_next_s = SHIFT;
               end else if (op == SH_SWAP) begin
                  dout_next_s  = sh_y_s;
                  state_next_s = DONE;
               end else begin
                  dout_next_s  = din;
                  state_next_s = DONE;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            dout_next_s  = sh_y_s;
            count_next_s = count_r - {{(AMT_W-1){1'b0}}, 1'b1};
            if (count_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
               state_next_s = DONE;
            end else begin
               state_next_s = SHIFT;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, datapath registers and registered busy/done decodes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         count_r <= {AMT_W{1'b0}};
         op_r    <= 3'b000;
         fill_r  <= 1'b0;
         dout_r  <= {BW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         count_r <= count_next_s;
         op_r    <= op_next_s;
         fill_r  <= fill_next_s;
         dout_r  <= dout_next_s;
         busy_r  <= (state_next_s != IDLE);
         done_r  <= (state_next_s == DONE);
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign dout = dout_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed testbench for shift_seq_ctrl with hand-computed expected results.
module tb_shift_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [15:0] din;
   logic [3:0]  amt;
   logic        fill;
   logic        busy;
   logic        done;
   logic [15:0] dout;

   int checks = 0;
   int errors = 0;

   shift_seq_ctrl #(.BW(16), .AMT_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .din   (din),
      .amt   (amt),
      .fill  (fill),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issue one command, measure cycles to done, check result and pulse width.
   task automatic run_cmd(input string tag, input logic [2:0] o, input logic [15:0] d,
                          input logic [3:0] a, input logic f,
                          input logic [15:0] exp_dout, input int exp_lat);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; din = d; amt = a; fill = f;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'b000; din = 16'h0000; amt = 4'd0; fill = 1'b0;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      n = 1;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_dout"}, {16'd0, dout}, {16'd0, exp_dout});
      @(posedge clk);
      #1;
      check({tag, "_done_off"}, {31'd0, done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_hold"}, {16'd0, dout}, {16'd0, exp_dout});
   endtask

   initial begin
      int n;
      int pulses;
      rst = 1'b1; start = 1'b0; op = 3'b000; din = 16'h0000; amt = 4'd0; fill = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_dout", {16'd0, dout}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_cmd("lsl4",   3'b011, 16'h0001, 4'd4,  1'b0, 16'h0010, 5);
      run_cmd("asr3",   3'b001, 16'h8000, 4'd3,  1'b0, 16'hF000, 4);
      run_cmd("lsr2f",  3'b010, 16'h0000, 4'd2,  1'b1, 16'hC000, 3);
      run_cmd("rol15",  3'b101, 16'h8001, 4'd15, 1'b0, 16'hC000, 16);
      run_cmd("ror1",   3'b100, 16'h0001, 4'd1,  1'b0, 16'h8000, 2);
      run_cmd("swap",   3'b110, 16'h12AB, 4'd7,  1'b0, 16'h12BA, 1);
      run_cmd("amt0",   3'b010, 16'h1234, 4'd0,  1'b0, 16'h1234, 1);
      run_cmd("pass7",  3'b111, 16'hA5A5, 4'd5,  1'b1, 16'hA5A5, 1);
      run_cmd("lslf3",  3'b011, 16'h0000, 4'd3,  1'b1, 16'h0007, 4);
      run_cmd("asrpos", 3'b001, 16'h4000, 4'd2,  1'b1, 16'h1000, 3);

      // start held high with new operands through SHIFT and the DONE cycle
      @(negedge clk);
      start = 1'b1; op = 3'b011; din = 16'h0001; amt = 4'd4; fill = 1'b0;
      @(posedge clk);
      #1;
      op = 3'b110; din = 16'hFFFF; amt = 4'd0; fill = 1'b1;
      n = 1;
      pulses = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done) pulses++;
      check("ign_lat", n, 5);
      check("ign_dout", {16'd0, dout}, 32'h0010);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done) pulses++;
         @(posedge clk);
         #1;
      end
      check("ign_pulses", pulses, 1);
      check("ign_hold", {16'd0, dout}, 32'h0010);

      // asynchronous reset in the middle of a 10-step command
      @(negedge clk);
      start = 1'b1; op = 3'b011; din = 16'h0001; amt = 4'd10; fill = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_dout", {16'd0, dout}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("arst_nodone", pulses, 0);
      run_cmd("post", 3'b100, 16'h0001, 4'd1, 1'b0, 16'h8000, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
